// File: rtl/gato_pkg.sv
// Shared tic-tac-toe types: cell encoding, board layout, board size constants and the
// placement controller FSM states. Also imported by the downstream win detector.
package gato_pkg;

    localparam int unsigned N_CELLS = 9;
    localparam int unsigned MAX_POS = 8;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_O     = 2'b01,
        CELL_X     = 2'b10
    } cell_t;

    typedef cell_t [N_CELLS-1:0] board_t;

    typedef enum logic {
        S_PLAY,
        S_DONE
    } state_t;

endpackage

// File: rtl/placement_ctrl_if.sv
// Button/board bundle between the player front end and placement_ctrl.
// Ports:
//   mover, colocar, game_over - cursor button, place button, win flag from detector
//   pos, board, jugador       - cursor cell, 3x3 board, player to move (1 = X)
//   place_pulse, timeout_pulse - one-cycle strobes
//   move_count, locked        - occupied cells, play frozen
// Modports: master = button/detector side, slave = controller side.
interface placement_ctrl_if;
    import gato_pkg::*;

    logic       mover;
    logic       colocar;
    logic       game_over;
    logic [3:0] pos;
    board_t     board;
    logic       jugador;
    logic       place_pulse;
    logic       timeout_pulse;
    logic [3:0] move_count;
    logic       locked;

    modport master (
        output mover, colocar, game_over,
        input  pos, board, jugador, place_pulse, timeout_pulse, move_count, locked
    );

    modport slave (
        input  mover, colocar, game_over,
        output pos, board, jugador, place_pulse, timeout_pulse, move_count, locked
    );

endinterface

// File: rtl/placement_ctrl_turn_timer.sv
// turn_timer: counts 0..TURN_CYCLES-1 while enabled, strobes expire_o on the last count
// and wraps to 0. clr_i restarts the count and takes priority over counting.
// Ports: clk, rst (sync, active-high), en_i, clr_i, expire_o.
module turn_timer #(
    parameter int unsigned TURN_CYCLES = 500_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int unsigned CntW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TURN_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expire_o = en_i && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/placement_ctrl.sv
// placement_ctrl: turns debounced buttons into cursor moves and legal mark placements.
// Owns the board, the player-to-move flag and the per-turn timeout; freezes on the
// detector's game_over or on a full board.
// Ports: clk, rst (sync, active-high), bus (placement_ctrl_if.slave).
// Optional build macro AUTO_PLACE_EN: on timeout, write the current player's mark into
// the lowest-index empty cell instead of only passing the turn.
module placement_ctrl
    import gato_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 500_000_000
) (
    input logic             clk,
    input logic             rst,
    placement_ctrl_if.slave bus
);

    state_t     state_q, state_d;
    logic       mover_q, mover_d;
    logic       colocar_q, colocar_d;
    logic [3:0] pos_q, pos_d;
    board_t     board_q, board_d;
    logic       jugador_q, jugador_d;
    logic [3:0] move_count_q, move_count_d;
    logic       place_pulse_q, place_pulse_d;
    logic       timeout_pulse_q, timeout_pulse_d;

    logic  mover_ev, colocar_ev, active, legal_place, tmr_expire, timeout;
    cell_t mark;

    // game_over in the same cycle as an event blocks it: the lock wins.
    always_comb begin
        mover_ev    = bus.mover && !mover_q;
        colocar_ev  = bus.colocar && !colocar_q;
        active      = (state_q == S_PLAY) && !bus.game_over;
        legal_place = active && colocar_ev && (board_q[pos_q] == CELL_EMPTY);
        timeout     = tmr_expire && !legal_place;
        mark        = jugador_q ? CELL_X : CELL_O;
    end

    turn_timer #(
        .TURN_CYCLES(TURN_CYCLES)
    ) u_turn_timer (
        .clk     (clk),
        .rst     (rst),
        .en_i    (active),
        .clr_i   (legal_place),
        .expire_o(tmr_expire)
    );

`ifdef AUTO_PLACE_EN
    logic [3:0] free_idx;

    // Lowest-index empty cell; only consulted in S_PLAY, where one always exists.
    always_comb begin
        free_idx = '0;
        for (int i = N_CELLS - 1; i >= 0; i--) begin
            if (board_q[i] == CELL_EMPTY) free_idx = 4'(i);
        end
    end
`endif

    always_comb begin
        state_d         = state_q;
        mover_d         = bus.mover;
        colocar_d       = bus.colocar;
        pos_d           = pos_q;
        board_d         = board_q;
        jugador_d       = jugador_q;
        move_count_d    = move_count_q;
        place_pulse_d   = 1'b0;
        timeout_pulse_d = 1'b0;

        if (active && mover_ev) begin
            pos_d = (pos_q == 4'(MAX_POS)) ? 4'd0 : pos_q + 4'd1;
        end

        // Placement uses the pre-increment cursor.
        if (legal_place) begin
            board_d[pos_q] = mark;
            jugador_d      = !jugador_q;
            move_count_d   = move_count_q + 4'd1;
            place_pulse_d  = 1'b1;
        end else if (timeout) begin
            jugador_d       = !jugador_q;
            timeout_pulse_d = 1'b1;
`ifdef AUTO_PLACE_EN
            board_d[free_idx] = mark;
            move_count_d      = move_count_q + 4'd1;
`endif
        end

        if ((state_q == S_PLAY) && (bus.game_over || (move_count_d == 4'(N_CELLS)))) begin
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_PLAY;
            mover_q         <= 1'b0;
            colocar_q       <= 1'b0;
            pos_q           <= '0;
            board_q         <= '0;
            jugador_q       <= 1'b1;
            move_count_q    <= '0;
            place_pulse_q   <= 1'b0;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            mover_q         <= mover_d;
            colocar_q       <= colocar_d;
            pos_q           <= pos_d;
            board_q         <= board_d;
            jugador_q       <= jugador_d;
            move_count_q    <= move_count_d;
            place_pulse_q   <= place_pulse_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    assign bus.pos           = pos_q;
    assign bus.board         = board_q;
    assign bus.jugador       = jugador_q;
    assign bus.place_pulse   = place_pulse_q;
    assign bus.timeout_pulse = timeout_pulse_q;
    assign bus.move_count    = move_count_q;
    assign bus.locked        = (state_q == S_DONE);

endmodule
